// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory controller: FSM states,
// port-select encodings and the wait-state counter width.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int WS_W = 4;

endpackage

// File: rtl/cpu_mem_array.sv
// Single-port synchronous RAM, WIDTH x 2**ADDRSIZE, registered read data.
// The storage array is called mem so it can be preloaded from a bench.
module cpu_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDRSIZE)-1];

    // rdata only moves on reads, so a write leaves the last read word in place
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Shares one synchronous RAM between the CPU fetch and load/store ports with
// alternating-priority arbitration; CPU_MEM_DUMP_EN adds the halt-triggered dump.
module cpu_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDRSIZE    = 12,
    parameter int WAIT_STATES = 1,
    parameter int DUMP_WORDS  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDRSIZE-1:0] i_addr,
    output logic [WIDTH-1:0]    i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic [WIDTH-1:0]    d_rdata,
    output logic                d_ack,
    input  logic                halt,
    output logic                dump_valid,
    output logic [ADDRSIZE-1:0] dump_addr,
    output logic [WIDTH-1:0]    dump_data,
    output logic                dump_done
);

    state_t              state_reg, state_next;
    logic [WS_W-1:0]     cnt_reg;
    logic                prio_reg, port_reg, we_reg;
    logic [ADDRSIZE-1:0] addr_reg;
    logic [WIDTH-1:0]    wdata_reg, i_hold_reg, d_hold_reg;
    logic                i_ack_reg, d_ack_reg;
    logic                grant, grant_port, finish;
    logic                arr_en, arr_we;
    logic [ADDRSIZE-1:0] arr_addr;
    logic [WIDTH-1:0]    arr_rdata;

`ifdef CPU_MEM_DUMP_EN
    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(DUMP_WORDS - 1);
    logic                halt_q_reg, halt_pend_reg, halt_rise;
    logic [ADDRSIZE-1:0] dcnt_reg, dump_addr_reg;
    logic                dump_valid_reg, dump_done_reg;

    assign halt_rise = halt & ~halt_q_reg;
`else
    logic unused_halt;
    assign unused_halt = halt ^ (DUMP_WORDS < 1);
`endif

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        grant_port = PORT_D;
        finish     = 1'b0;
        arr_en     = 1'b0;
        arr_we     = 1'b0;
        arr_addr   = addr_reg;
        if (i_req && d_req) begin
            grant_port = prio_reg;
        end else if (i_req) begin
            grant_port = PORT_I;
        end
        case (state_reg)
            IDLE: begin
                // an ack still on the wire blocks acceptance for that edge
                if ((i_req || d_req) && !(i_ack_reg || d_ack_reg)) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                end
`ifdef CPU_MEM_DUMP_EN
                if (halt_rise) begin
                    grant      = 1'b0;
                    state_next = DUMP;
                end
`endif
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    finish     = 1'b1;
                    arr_en     = 1'b1;
                    arr_we     = we_reg;
                    state_next = IDLE;
`ifdef CPU_MEM_DUMP_EN
                    if (halt_pend_reg || halt_rise) begin
                        state_next = DUMP;
                    end
`endif
                end
            end
`ifdef CPU_MEM_DUMP_EN
            DUMP: begin
                arr_en   = 1'b1;
                arr_addr = dcnt_reg;
                if (dcnt_reg == LAST_ADDR) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            prio_reg   <= PORT_D;
            port_reg   <= PORT_D;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            i_ack_reg  <= 1'b0;
            d_ack_reg  <= 1'b0;
            i_hold_reg <= '0;
            d_hold_reg <= '0;
        end else begin
            i_ack_reg <= finish && (port_reg == PORT_I);
            d_ack_reg <= finish && (port_reg == PORT_D);
            if (grant) begin
                port_reg  <= grant_port;
                prio_reg  <= ~grant_port;
                we_reg    <= (grant_port == PORT_D) && d_we;
                addr_reg  <= (grant_port == PORT_I) ? i_addr : d_addr;
                wdata_reg <= d_wdata;
                cnt_reg   <= WS_W'(WAIT_STATES);
            end else if (state_reg == BUSY && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            // capture the word on its ack cycle so each port keeps its last value
            if (i_ack_reg) begin
                i_hold_reg <= arr_rdata;
            end
            if (d_ack_reg && !we_reg) begin
                d_hold_reg <= arr_rdata;
            end
        end
    end

    assign i_ack   = i_ack_reg;
    assign d_ack   = d_ack_reg;
    assign i_rdata = i_ack_reg ? arr_rdata : i_hold_reg;
    assign d_rdata = (d_ack_reg && !we_reg) ? arr_rdata : d_hold_reg;

`ifdef CPU_MEM_DUMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q_reg     <= 1'b0;
            halt_pend_reg  <= 1'b0;
            dcnt_reg       <= '0;
            dump_addr_reg  <= '0;
            dump_valid_reg <= 1'b0;
            dump_done_reg  <= 1'b0;
        end else begin
            halt_q_reg <= halt;
            if (state_reg == BUSY && halt_rise) begin
                halt_pend_reg <= 1'b1;
            end
            if (state_reg == DUMP) begin
                dump_valid_reg <= 1'b1;
                dump_addr_reg  <= dcnt_reg;
                dcnt_reg       <= dcnt_reg + 1'b1;
            end else if (state_reg == DONE) begin
                dump_valid_reg <= 1'b0;
                dump_done_reg  <= 1'b1;
            end
        end
    end

    assign dump_valid = dump_valid_reg;
    assign dump_addr  = dump_addr_reg;
    assign dump_data  = dump_valid_reg ? arr_rdata : '0;
    assign dump_done  = dump_done_reg;
`else
    assign dump_valid = 1'b0;
    assign dump_addr  = '0;
    assign dump_data  = '0;
    assign dump_done  = 1'b0;
`endif

    cpu_mem_array #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_reg),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Scoreboard bench for cpu_mem_ctrl: one instance with one wait state and one
// with zero wait states; dump checks apply when CPU_MEM_DUMP_EN is defined.
module tb_cpu_mem_ctrl;

    localparam int W = 32;
    localparam int A = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   i_req, d_req, d_we, i_ack, d_ack, dump_valid, dump_done;
    logic         halt, halt_off;
    logic [A-1:0] i_addr [2];
    logic [A-1:0] d_addr [2];
    logic [A-1:0] dump_addr [2];
    logic [W-1:0] d_wdata [2];
    logic [W-1:0] i_rdata [2];
    logic [W-1:0] d_rdata [2];
    logic [W-1:0] dump_data [2];

    cpu_mem_ctrl #(.WIDTH(W), .ADDRSIZE(A), .WAIT_STATES(1), .DUMP_WORDS(10)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .halt(halt),
        .dump_valid(dump_valid[0]), .dump_addr(dump_addr[0]),
        .dump_data(dump_data[0]), .dump_done(dump_done[0])
    );

    cpu_mem_ctrl #(.WIDTH(W), .ADDRSIZE(A), .WAIT_STATES(0), .DUMP_WORDS(10)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .halt(halt_off),
        .dump_valid(dump_valid[1]), .dump_addr(dump_addr[1]),
        .dump_data(dump_data[1]), .dump_done(dump_done[1])
    );

    typedef struct {
        logic         port;
        logic [W-1:0] ie;
        logic [W-1:0] de;
        int           cyc;
    } exp_t;

    exp_t         sb0 [$];
    exp_t         sb1 [$];
    logic [W-1:0] mem_m [2][16];
    logic [W-1:0] ih_m [2];
    logic [W-1:0] dh_m [2];
    int           checks = 0;
    int           errors = 0;
    int           d_idx = 0;
    int           d_start = -1000;
    bit           d_done_seen = 1'b0;

    function automatic int ws(input int w);
        return (w == 0) ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] pat(input int a);
        return (a == 5) ? 32'hDEADBEEF : {16'hC0DE, 16'(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int w, input logic port, input logic we, input int addr,
                        input logic [W-1:0] data, input int c);
        exp_t e;
        if (port) ih_m[w] = mem_m[w][addr];
        else if (we) mem_m[w][addr] = data;
        else dh_m[w] = mem_m[w][addr];
        e.port = port;
        e.ie   = ih_m[w];
        e.de   = dh_m[w];
        e.cyc  = c;
        if (w == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic mon(input int w);
        exp_t e;
        bit   empty;
        if (i_ack[w] || d_ack[w]) begin
            empty = (w == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                chk($sformatf("u%0d_unexpected_ack", w), {62'b0, i_ack[w], d_ack[w]}, 64'd0);
            end else begin
                if (w == 0) e = sb0.pop_front();
                else e = sb1.pop_front();
                $display("u%0d ack port=%0d cyc=%0d i_rdata=%h d_rdata=%h", w, e.port, cyc,
                         i_rdata[w], d_rdata[w]);
                chk($sformatf("u%0d_ack_pair", w), {62'b0, i_ack[w], d_ack[w]},
                    e.port ? 64'd2 : 64'd1);
                chk($sformatf("u%0d_ack_cycle", w), cyc, e.cyc);
                chk($sformatf("u%0d_i_rdata", w), i_rdata[w], e.ie);
                chk($sformatf("u%0d_d_rdata", w), d_rdata[w], e.de);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0);
            mon(1);
        end
    end

`ifdef CPU_MEM_DUMP_EN
    always @(negedge clk) begin
        if (rst) begin
            if (dump_valid[0]) begin
                $display("dump idx=%0d addr=%0d data=%h cyc=%0d", d_idx, dump_addr[0],
                         dump_data[0], cyc);
                chk("dump_addr", dump_addr[0], d_idx);
                chk("dump_data", dump_data[0], (d_idx < 16) ? mem_m[0][d_idx] : 'x);
                chk("dump_cycle", cyc, d_start + d_idx);
                d_idx++;
            end
            if (dump_done[0] && !d_done_seen) begin
                d_done_seen = 1'b1;
                chk("dump_done_cycle", cyc, d_start + 10);
                chk("dump_word_count", d_idx, 10);
            end
        end
    end
`endif

    task automatic chk_zero(input string nm);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("%s_u%0d_flags", nm, w),
                {60'b0, i_ack[w], d_ack[w], dump_valid[w], dump_done[w]}, 64'd0);
            chk($sformatf("%s_u%0d_i_rdata", nm, w), i_rdata[w], 64'd0);
            chk($sformatf("%s_u%0d_d_rdata", nm, w), d_rdata[w], 64'd0);
            chk($sformatf("%s_u%0d_dump", nm, w), {dump_addr[w], dump_data[w]}, 64'd0);
        end
    endtask

    task automatic access(input int w, input logic port, input logic we, input int addr,
                          input logic [W-1:0] data);
        bit got = 1'b0;
        push(w, port, we, addr, data, cyc + 2 + ws(w));
        if (port) begin
            i_req[w]  = 1'b1;
            i_addr[w] = A'(addr);
        end else begin
            d_req[w]   = 1'b1;
            d_we[w]    = we;
            d_addr[w]  = A'(addr);
            d_wdata[w] = data;
        end
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = port ? i_ack[w] : d_ack[w];
        end
        if (!got) chk($sformatf("u%0d_access_timeout", w), 64'd0, 64'd1);
        i_req[w] = 1'b0;
        d_req[w] = 1'b0;
        d_we[w]  = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_holds();
        for (int w = 0; w < 2; w++) begin
            ih_m[w] = '0;
            dh_m[w] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  e;
        bit  got;
        i_req = '0; d_req = '0; d_we = '0; halt = 1'b0; halt_off = 1'b0;
        for (int w = 0; w < 2; w++) begin
            i_addr[w] = '0; d_addr[w] = '0; d_wdata[w] = '0;
        end
        clear_holds();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 10; a++) access(0, 1'b0, 1'b1, a, pat(a));

        // write in flight is aborted by reset; mem[5] must keep DEADBEEF
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 5; d_wdata[0] = 32'hBAD0BAD0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("reset_busy");
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        clear_holds();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        e = cyc;
        i_req[0] = 1'b1; i_addr[0] = 1;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 2;
        push(0, 1'b0, 1'b0, 2, '0, e + 3);
        push(0, 1'b1, 1'b0, 1, '0, e + 7);
        push(0, 1'b0, 1'b0, 2, '0, e + 11);
        push(0, 1'b1, 1'b0, 1, '0, e + 15);
        repeat (15) @(negedge clk);
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        @(negedge clk);

        access(0, 1'b1, 1'b0, 5, '0);
        access(0, 1'b0, 1'b1, 3, 32'h12345678);
        access(0, 1'b0, 1'b0, 3, '0);
        access(0, 1'b1, 1'b0, 3, '0);

        access(1, 1'b0, 1'b1, 4, 32'hCAFEF00D);
        access(1, 1'b1, 1'b0, 4, '0);
        e = cyc;
        i_req[1] = 1'b1; i_addr[1] = 4;
        push(1, 1'b1, 1'b0, 4, '0, e + 2);
        push(1, 1'b1, 1'b0, 4, '0, e + 5);
        repeat (5) @(negedge clk);
        i_req[1] = 1'b0;
        @(negedge clk);

`ifdef CPU_MEM_DUMP_EN
        e = cyc;
        push(0, 1'b1, 1'b0, 7, '0, e + 3);
        i_req[0] = 1'b1; i_addr[0] = 7;
        d_start = e + 4; d_idx = 0; d_done_seen = 1'b0;
        @(negedge clk);
        halt = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = i_ack[0];
        end
        i_req[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = dump_done[0];
        end
        chk("dump_done_reached", got, 1);
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        repeat (10) @(negedge clk);
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("dump_done_sticky", {dump_valid[0], dump_done[0]}, 64'd1);

        halt = 1'b0;
        #2 rst = 1'b0;
        clear_holds();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        e = cyc;
        halt = 1'b1;
        d_start = e + 2; d_idx = 0; d_done_seen = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        halt = 1'b0;
        #1 chk_zero("reset_dump");
        chk("dump_words_before_abort", d_idx, 2);
        d_start = -1000;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("dump_abort_state", {dump_valid[0], dump_done[0]}, 64'd0);
`else
        halt = 1'b1;
        access(0, 1'b1, 1'b0, 7, '0);
        repeat (3) @(negedge clk);
        chk("halt_ignored_dump", {dump_valid[0], dump_done[0]}, 64'd0);
        chk("halt_ignored_data", {dump_addr[0], dump_data[0]}, 64'd0);
        halt = 1'b0;
`endif

        chk("u0_scoreboard_empty", sb0.size(), 0);
        chk("u1_scoreboard_empty", sb1.size(), 0);
        chk("u1_dump_idle", {dump_valid[1], dump_done[1]}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
